// File: rtl/edge_arb_pkg.sv
// Shared types and helpers for the edge event arbiter: FSM state encoding,
// channel-index width helper and the default channel count.
package edge_arb_pkg;

  localparam int NUM_CH_DEFAULT = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_t;

  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One event channel: 2-flop synchroniser, previous-sample flop and trigger
// qualification; o_edge is combinational from the synchroniser output.
module edge_chan #(
  parameter bit TRIG_RISE = 1'b1,
  parameter bit TRIG_FALL = 1'b0,
  parameter bit RST_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  input  logic i_enable,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_rise;
  logic w_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
      r_prev  <= RST_VAL;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;
  assign o_edge = i_enable & ((TRIG_RISE & w_rise) | (TRIG_FALL & w_fall));

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge-detected event lines serialised round-robin onto one valid/ready port.
// Optional sticky overrun flags are built when OVERRUN_TRACK_EN is defined.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEFAULT,
  parameter bit TRIG_RISE = 1'b1,
  parameter bit TRIG_FALL = 1'b0,
  parameter bit RST_VAL   = 1'b0,
  localparam int CH_W     = ch_w(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_async_in,
  input  logic [NUM_CH-1:0] i_ch_enable,
  output logic              o_evt_valid,
  input  logic              i_evt_ready,
  output logic [CH_W-1:0]   o_evt_ch,
`ifdef OVERRUN_TRACK_EN
  output logic [NUM_CH-1:0] o_overrun,
  input  logic              i_clr_overrun,
`endif
  output logic [NUM_CH-1:0] o_evt_pending
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [NUM_CH-1:0] w_edge;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] w_pending_nxt;
  logic [NUM_CH-1:0] w_hs_vec;
  logic [NUM_CH-1:0] w_offer_vec;
  logic [CH_W-1:0]   r_evt_ch;
  logic [CH_W-1:0]   r_last_grant;
  logic [CH_W-1:0]   w_sel_ch;
  logic              w_sel_found;
  logic              w_hs;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    edge_chan #(
      .TRIG_RISE (TRIG_RISE),
      .TRIG_FALL (TRIG_FALL),
      .RST_VAL   (RST_VAL)
    ) u_chan (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_async  (i_async_in[g]),
      .i_enable (i_ch_enable[g]),
      .o_edge   (w_edge[g])
    );
  end

  assign w_hs = o_evt_valid & i_evt_ready;

  // Round-robin: first pending bit after the last granted channel, wrapping.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_ch    = '0;
    for (int j = 1; j <= NUM_CH; j++) begin
      if (!w_sel_found && r_pending[(int'(r_last_grant) + j) % NUM_CH]) begin
        w_sel_found = 1'b1;
        w_sel_ch    = CH_W'((int'(r_last_grant) + j) % NUM_CH);
      end
    end
  end

  always_comb begin
    w_hs_vec    = '0;
    w_offer_vec = '0;
    if (w_hs) w_hs_vec[r_evt_ch] = 1'b1;
    if (r_state == ARB_OFFER) w_offer_vec[r_evt_ch] = 1'b1;
    // A new edge wins over a clear; the offered channel survives disable.
    w_pending_nxt = w_edge | (r_pending & ~w_hs_vec & (i_ch_enable | w_offer_vec));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ARB_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:  if (w_sel_found) w_state_nxt = ARB_OFFER;
      ARB_OFFER: if (w_hs)        w_state_nxt = ARB_IDLE;
      default:                    w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    o_evt_valid = (r_state == ARB_OFFER);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending    <= '0;
      r_evt_ch     <= '0;
      r_last_grant <= CH_W'(NUM_CH - 1);
    end else begin
      r_pending <= w_pending_nxt;
      if (r_state == ARB_IDLE && w_sel_found) r_evt_ch <= w_sel_ch;
      if (w_hs) r_last_grant <= r_evt_ch;
    end
  end

  assign o_evt_ch      = r_evt_ch;
  assign o_evt_pending = r_pending;

`ifdef OVERRUN_TRACK_EN
  logic [NUM_CH-1:0] r_overrun;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overrun <= '0;
    end else begin
      r_overrun <= (r_overrun & {NUM_CH{~i_clr_overrun}})
                 | (w_edge & r_pending & ~w_hs_vec);
    end
  end

  assign o_overrun = r_overrun;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (NUM_CH=4, rising edges); covers
// latency, ordering, fairness, backpressure, disable, reset and overrun.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] async_in;
  logic [3:0] ch_enable;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic [3:0] evt_pending;
`ifdef OVERRUN_TRACK_EN
  logic [3:0] overrun;
  logic       clr_overrun;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int grants[8];
  int n_grants;

  always #5 clk = ~clk;

  edge_event_arbiter #(
    .NUM_CH    (4),
    .TRIG_RISE (1'b1),
    .TRIG_FALL (1'b0),
    .RST_VAL   (1'b0)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_async_in    (async_in),
    .i_ch_enable   (ch_enable),
    .o_evt_valid   (evt_valid),
    .i_evt_ready   (evt_ready),
    .o_evt_ch      (evt_ch),
`ifdef OVERRUN_TRACK_EN
    .o_overrun     (overrun),
    .i_clr_overrun (clr_overrun),
`endif
    .o_evt_pending (evt_pending)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    evt_ready = 1'b1;
    ticks(5);
    while ((evt_pending != 4'b0 || evt_valid) && n < 60) begin
      tick();
      n++;
    end
    chk(tag, {27'b0, evt_valid, evt_pending}, 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    async_in  = 4'b0;
    ch_enable = 4'hF;
    evt_ready = 1'b0;
`ifdef OVERRUN_TRACK_EN
    clr_overrun = 1'b0;
`endif
    ticks(3);
    rst = 1'b0;
    chk("rst_valid",   {31'b0, evt_valid}, 32'd0);
    chk("rst_pending", {28'b0, evt_pending}, 32'd0);
    chk("rst_ch",      {30'b0, evt_ch}, 32'd0);
`ifdef OVERRUN_TRACK_EN
    chk("rst_overrun", {28'b0, overrun}, 32'd0);
`endif
    ticks(3);

    // Single rise on ch2, ready high: valid exactly 4 edges later
    evt_ready   = 1'b1;
    async_in[2] = 1'b1;
    ticks(2);
    chk("lat_k2_valid",   {31'b0, evt_valid}, 32'd0);
    tick();
    chk("lat_k3_valid",   {31'b0, evt_valid}, 32'd0);
    chk("lat_k3_pending", {28'b0, evt_pending}, 32'h4);
    tick();
    chk("lat_k4_valid",   {31'b0, evt_valid}, 32'd1);
    chk("lat_k4_ch",      {30'b0, evt_ch}, 32'd2);
    tick();
    chk("lat_k5_valid",   {31'b0, evt_valid}, 32'd0);
    chk("lat_k5_pending", {28'b0, evt_pending}, 32'h0);

    // Back to reset state so channel 0 has priority again
    async_in = 4'b0;
    ticks(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(2);

    // Simultaneous rises on ch0, ch1, ch3
    async_in = 4'b1011;
    ticks(3);
    chk("sim_pending", {28'b0, evt_pending}, 32'hB);
    tick();
    chk("sim_v0", {31'b0, evt_valid}, 32'd1);
    chk("sim_c0", {30'b0, evt_ch}, 32'd0);
    tick();
    chk("sim_gap0", {31'b0, evt_valid}, 32'd0);
    tick();
    chk("sim_v1", {31'b0, evt_valid}, 32'd1);
    chk("sim_c1", {30'b0, evt_ch}, 32'd1);
    tick();
    chk("sim_gap1", {31'b0, evt_valid}, 32'd0);
    tick();
    chk("sim_v3", {31'b0, evt_valid}, 32'd1);
    chk("sim_c3", {30'b0, evt_ch}, 32'd3);
    tick();
    chk("sim_end_valid",   {31'b0, evt_valid}, 32'd0);
    chk("sim_end_pending", {28'b0, evt_pending}, 32'h0);
    async_in = 4'b0;
    ticks(4);

    // Round-robin: ch1 and ch2 re-pend continuously
    n_grants = 0;
    async_in = 4'b0110;
    for (int c = 0; c < 60 && n_grants < 8; c++) begin
      tick();
      async_in = async_in ^ 4'b0110;
      if (evt_valid && evt_ready) begin
        grants[n_grants] = int'(evt_ch);
        n_grants++;
      end
    end
    chk("rr_count", n_grants, 32'd8);
    for (int i = 0; i < n_grants; i++)
      chk($sformatf("rr_grant%0d", i), grants[i], (i % 2 == 0) ? 32'd1 : 32'd2);
    async_in = 4'b0;
    drain("rr_drain");

    // Backpressure on ch3, ch0 arrives while stalled
    evt_ready   = 1'b0;
    async_in[3] = 1'b1;
    ticks(4);
    chk("bp_valid", {31'b0, evt_valid}, 32'd1);
    chk("bp_ch",    {30'b0, evt_ch}, 32'd3);
    async_in[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i), {29'b0, evt_valid, evt_ch}, {29'b0, 1'b1, 2'd3});
    end
    chk("bp_pending", {28'b0, evt_pending}, 32'h9);
    evt_ready = 1'b1;
    tick();
    chk("bp_hs_valid",   {31'b0, evt_valid}, 32'd0);
    chk("bp_hs_pending", {28'b0, evt_pending}, 32'h1);
    tick();
    chk("bp_next_valid", {31'b0, evt_valid}, 32'd1);
    chk("bp_next_ch",    {30'b0, evt_ch}, 32'd0);
    tick();
    chk("bp_done", {27'b0, evt_valid, evt_pending}, 32'h0);

    // Disabled channel produces nothing
    ch_enable[1] = 1'b0;
    async_in[1]  = 1'b1;
    ticks(6);
    chk("dis_valid",   {31'b0, evt_valid}, 32'd0);
    chk("dis_pending", {28'b0, evt_pending}, 32'h0);
    ch_enable[1] = 1'b1;
    ticks(3);
    chk("dis_reen_pending", {28'b0, evt_pending}, 32'h0);

    // Reset during an offer
    evt_ready   = 1'b0;
    async_in[2] = 1'b1;
    ticks(4);
    chk("rmo_valid", {31'b0, evt_valid}, 32'd1);
    chk("rmo_ch",    {30'b0, evt_ch}, 32'd2);
    rst = 1'b1;
    tick();
    chk("rmo_after_valid",   {31'b0, evt_valid}, 32'd0);
    chk("rmo_after_pending", {28'b0, evt_pending}, 32'h0);
    async_in = 4'b0;
    rst      = 1'b0;
    drain("rmo_drain");

`ifdef OVERRUN_TRACK_EN
    // Two ch2 rises six cycles apart while stalled
    evt_ready   = 1'b0;
    async_in[2] = 1'b1;
    ticks(3);
    async_in[2] = 1'b0;
    ticks(3);
    chk("ovr_before", {28'b0, overrun}, 32'h0);
    async_in[2] = 1'b1;
    ticks(4);
    chk("ovr_set", {28'b0, overrun}, 32'h4);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovr_clr", {28'b0, overrun}, 32'h0);
    async_in = 4'b0;
    drain("ovr_drain");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
